// File: rtl/axis_mem_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : axis_mem_write_arbiter_if
// Purpose  : AXI-Stream beat bundle (tdata/tstrb/tvalid/tlast/tready) used by
//            the write arbiter for both requester and memory-side ports.
// Revision : 1.0 - initial release
// ============================================================================
interface axis_mem_write_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic                    tvalid;
    logic                    tlast;
    logic                    tready;

    // Stream source: drives the payload, observes backpressure
    modport master (
        output tdata,
        output tstrb,
        output tvalid,
        output tlast,
        input  tready
    );

    // Stream sink: observes the payload, drives backpressure
    modport slave (
        input  tdata,
        input  tstrb,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface
`default_nettype wire

// File: rtl/axis_mem_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axis_mem_write_arbiter
// Purpose  : Two-requester, packet-locked, round-robin AXI-Stream write
//            arbiter. A grant is held until the packet's last beat; packets
//            longer than MAX_BEATS are cut with a forced tlast and flagged.
//            Completed packets are counted per requester.
// Revision : 1.0 - initial release
// ============================================================================
module axis_mem_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BEATS  = 4096,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                     axis_aclk,
    input  logic                     axis_aresetn,
    axis_mem_write_arbiter_if.slave  s00_axis,
    axis_mem_write_arbiter_if.slave  s01_axis,
    axis_mem_write_arbiter_if.master m00_axis,
    output logic [CNT_WIDTH-1:0]     pkt_cnt0,
    output logic [CNT_WIDTH-1:0]     pkt_cnt1,
    output logic                     err_overrun
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int BEAT_WIDTH = $clog2(MAX_BEATS + 1);
    // Beat index at which tlast is forced regardless of the requester
    localparam logic [BEAT_WIDTH-1:0] LAST_BEAT = BEAT_WIDTH'(MAX_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic [BEAT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_WIDTH-1:0]  pkt_cnt0_q, pkt_cnt0_d;
    logic [CNT_WIDTH-1:0]  pkt_cnt1_q, pkt_cnt1_d;
    logic                  err_q, err_d;

    logic                  w_granted;
    logic                  w_sel1;
    logic [DATA_WIDTH-1:0] w_src_tdata;
    logic [STRB_WIDTH-1:0] w_src_tstrb;
    logic                  w_src_tvalid;
    logic                  w_src_tlast;
    logic                  w_force_last;
    logic                  w_m_tlast;
    logic                  w_beat;

    // Pick the currently granted requester's stream and detect a beat
    always_comb begin
        w_granted    = (state_q == GNT0) || (state_q == GNT1);
        w_sel1       = (state_q == GNT1);
        w_src_tdata  = w_sel1 ? s01_axis.tdata  : s00_axis.tdata;
        w_src_tstrb  = w_sel1 ? s01_axis.tstrb  : s00_axis.tstrb;
        w_src_tvalid = w_sel1 ? s01_axis.tvalid : s00_axis.tvalid;
        w_src_tlast  = w_sel1 ? s01_axis.tlast  : s00_axis.tlast;
        w_force_last = (beat_cnt_q == LAST_BEAT);
        w_m_tlast    = w_src_tlast | w_force_last;
        w_beat       = w_granted & w_src_tvalid & m00_axis.tready;
    end

    // Zero-latency passthrough while granted; everything quiet in IDLE
    always_comb begin
        m00_axis.tdata  = w_granted ? w_src_tdata : '0;
        m00_axis.tstrb  = w_granted ? w_src_tstrb : '0;
        m00_axis.tvalid = w_granted & w_src_tvalid;
        m00_axis.tlast  = w_granted & w_m_tlast;
        s00_axis.tready = (state_q == GNT0) & m00_axis.tready;
        s01_axis.tready = (state_q == GNT1) & m00_axis.tready;
    end

    // Next-state: arbitrate in IDLE, hold the grant until the (possibly forced) last beat
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        pkt_cnt0_d   = pkt_cnt0_q;
        pkt_cnt1_d   = pkt_cnt1_q;
        err_d        = err_q;
        case (state_q)
            IDLE: begin
                // With both requesting, the one not served last wins
                if (s00_axis.tvalid && (!s01_axis.tvalid || last_grant_q)) begin
                    state_d      = GNT0;
                    last_grant_d = 1'b0;
                end else if (s01_axis.tvalid) begin
                    state_d      = GNT1;
                    last_grant_d = 1'b1;
                end
            end
            GNT0, GNT1: begin
                if (w_beat) begin
                    if (w_m_tlast) begin
                        state_d    = IDLE;
                        beat_cnt_d = '0;
                        if (w_sel1) begin
                            pkt_cnt1_d = pkt_cnt1_q + CNT_WIDTH'(1);
                        end else begin
                            pkt_cnt0_d = pkt_cnt0_q + CNT_WIDTH'(1);
                        end
                        // A length cut rather than a real end of packet
                        if (!w_src_tlast) begin
                            err_d = 1'b1;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + BEAT_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                beat_cnt_d = '0;
            end
        endcase
    end

    // State and counter registers with asynchronous active-low reset
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            beat_cnt_q   <= '0;
            pkt_cnt0_q   <= '0;
            pkt_cnt1_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            pkt_cnt0_q   <= pkt_cnt0_d;
            pkt_cnt1_q   <= pkt_cnt1_d;
            err_q        <= err_d;
        end
    end

    assign pkt_cnt0    = pkt_cnt0_q;
    assign pkt_cnt1    = pkt_cnt1_q;
    assign err_overrun = err_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_mem_write_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_axis_mem_write_arbiter
// Purpose  : Self-checking bench for axis_mem_write_arbiter (MAX_BEATS=4,
//            CNT_WIDTH=2): directed scenarios plus randomized traffic against
//            a packet-level round-robin reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_mem_write_arbiter;
    localparam int DW   = 32;
    localparam int SW   = DW / 8;
    localparam int MAXB = 4;
    localparam int CW   = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic          last;
        int            cyc;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    axis_mem_write_arbiter_if #(.DATA_WIDTH(DW)) s00 ();
    axis_mem_write_arbiter_if #(.DATA_WIDTH(DW)) s01 ();
    axis_mem_write_arbiter_if #(.DATA_WIDTH(DW)) m00 ();

    logic [CW-1:0] pkt_cnt0;
    logic [CW-1:0] pkt_cnt1;
    logic          err_overrun;
    logic          m_ready = 1'b1;

    axis_mem_write_arbiter #(
        .DATA_WIDTH (DW),
        .MAX_BEATS  (MAXB),
        .CNT_WIDTH  (CW)
    ) dut (
        .axis_aclk    (clk),
        .axis_aresetn (rst_n),
        .s00_axis     (s00),
        .s01_axis     (s01),
        .m00_axis     (m00),
        .pkt_cnt0     (pkt_cnt0),
        .pkt_cnt1     (pkt_cnt1),
        .err_overrun  (err_overrun)
    );

    assign m00.tready = m_ready;

    beat_t q0[$];
    beat_t q1[$];
    beat_t obs[$];
    bit    rdy0_seen;
    bit    rdy1_seen;

    always @(posedge clk) cyc <= cyc + 1;

    // Requester sources: present the head of each queue, pop on handshake
    initial begin : drv
        bit h0, h1;
        s00.tvalid = 1'b0; s00.tdata = '0; s00.tstrb = '0; s00.tlast = 1'b0;
        s01.tvalid = 1'b0; s01.tdata = '0; s01.tstrb = '0; s01.tlast = 1'b0;
        forever begin
            @(negedge clk);
            h0 = s00.tvalid && s00.tready;
            h1 = s01.tvalid && s01.tready;
            @(posedge clk);
            #1;
            if (h0 && q0.size() > 0) void'(q0.pop_front());
            if (h1 && q1.size() > 0) void'(q1.pop_front());
            if (q0.size() > 0) begin
                s00.tvalid = 1'b1; s00.tdata = q0[0].data; s00.tstrb = q0[0].strb; s00.tlast = q0[0].last;
            end else begin
                s00.tvalid = 1'b0; s00.tdata = '0; s00.tstrb = '0; s00.tlast = 1'b0;
            end
            if (q1.size() > 0) begin
                s01.tvalid = 1'b1; s01.tdata = q1[0].data; s01.tstrb = q1[0].strb; s01.tlast = q1[0].last;
            end else begin
                s01.tvalid = 1'b0; s01.tdata = '0; s01.tstrb = '0; s01.tlast = 1'b0;
            end
        end
    end

    // Memory-side monitor: log every beat that will complete at the next edge
    initial begin : mon
        beat_t b;
        forever begin
            @(negedge clk);
            if (s00.tready === 1'b1) rdy0_seen = 1'b1;
            if (s01.tready === 1'b1) rdy1_seen = 1'b1;
            if (m00.tvalid === 1'b1 && m00.tready === 1'b1) begin
                b.data = m00.tdata; b.strb = m00.tstrb; b.last = m00.tlast; b.cyc = cyc;
                obs.push_back(b);
            end
        end
    end

    function automatic logic [DW-1:0] tag(input int s, input int n);
        return {s[0], 31'(n)};
    endfunction

    task automatic push(input int s, input logic [DW-1:0] d, input logic [SW-1:0] st, input logic l);
        beat_t b;
        b.data = d; b.strb = st; b.last = l; b.cyc = 0;
        if (s == 0) q0.push_back(b); else q1.push_back(b);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        obs.delete();
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        rdy0_seen = 1'b0;
        rdy1_seen = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (obs.size() < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        vectors++;
        if (obs.size() < n) begin
            miscompares++;
            $display("FAIL %s: %0d beats seen, %0d required", name, obs.size(), n);
        end
    endtask

    // Split one requester's beat stream into arbiter packets (tlast or length cut)
    function automatic void split(input beat_t src[$], output beat_t out[$], output int segs[$], inout bit forced);
        int n;
        beat_t b;
        n = 0;
        out.delete();
        segs.delete();
        foreach (src[j]) begin
            b = src[j];
            n++;
            if (b.last || n == MAXB) begin
                if (!b.last) forced = 1'b1;
                b.last = 1'b1;
                segs.push_back(n);
                n = 0;
            end
            out.push_back(b);
        end
    endfunction

    task automatic test_reset();
        #1 rst_n = 1'b0;
        push(0, 32'h1234_5678, 4'hF, 1'b1);
        repeat (2) @(posedge clk);
        #2;
        vectors++; if (m00.tvalid !== 1'b0) begin miscompares++; $display("FAIL rst_tvalid: got %b expected 0", m00.tvalid); end
        vectors++; if (m00.tlast !== 1'b0) begin miscompares++; $display("FAIL rst_tlast: got %b expected 0", m00.tlast); end
        vectors++; if (m00.tdata !== '0) begin miscompares++; $display("FAIL rst_tdata: got %h expected 0", m00.tdata); end
        vectors++; if (m00.tstrb !== '0) begin miscompares++; $display("FAIL rst_tstrb: got %h expected 0", m00.tstrb); end
        vectors++; if (s00.tready !== 1'b0 || s01.tready !== 1'b0) begin miscompares++; $display("FAIL rst_tready: got %b%b expected 00", s00.tready, s01.tready); end
        vectors++; if (pkt_cnt0 !== '0 || pkt_cnt1 !== '0) begin miscompares++; $display("FAIL rst_cnt: got %0d/%0d expected 0/0", pkt_cnt0, pkt_cnt1); end
        vectors++; if (err_overrun !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b expected 0", err_overrun); end
        do_reset();
    endtask

    task automatic test_single();
        int k;
        do_reset();
        @(negedge clk);
        #1;
        k = cyc;
        for (int j = 0; j < 3; j++) push(0, tag(0, 16'hA0 + j), 4'hF, j == 2);
        wait_beats(3, 20, "t1_beats");
        for (int j = 0; j < 3 && j < obs.size(); j++) begin
            vectors++;
            if (obs[j].data !== tag(0, 16'hA0 + j) || obs[j].last !== (j == 2) || obs[j].cyc != k + 2 + j) begin
                miscompares++;
                $display("FAIL t1_beat%0d: got data %h last %b cyc %0d expected %h %b %0d",
                         j, obs[j].data, obs[j].last, obs[j].cyc, tag(0, 16'hA0 + j), j == 2, k + 2 + j);
            end
        end
        @(posedge clk);
        #1;
        vectors++; if (pkt_cnt0 !== 2'd1) begin miscompares++; $display("FAIL t1_cnt0: got %0d expected 1", pkt_cnt0); end
        vectors++; if (rdy1_seen !== 1'b0) begin miscompares++; $display("FAIL t1_s01_ready: got %b expected 0", rdy1_seen); end
        vectors++; if (m00.tvalid !== 1'b0) begin miscompares++; $display("FAIL t1_idle: got %b expected 0", m00.tvalid); end
    endtask

    task automatic test_round_robin();
        int s;
        do_reset();
        for (int p = 0; p < 3; p++) begin
            for (int j = 0; j < 2; j++) begin
                push(0, tag(0, p * 2 + j), 4'h3, j == 1);
                push(1, tag(1, p * 2 + j), 4'hC, j == 1);
            end
        end
        wait_beats(12, 60, "t2_beats");
        for (int i = 0; i < 12 && i < obs.size(); i++) begin
            s = (i / 2) % 2;
            vectors++;
            if (obs[i].data !== tag(s, (i / 4) * 2 + (i % 2)) || obs[i].last !== (i % 2 == 1)) begin
                miscompares++;
                $display("FAIL t2_order%0d: got %h last %b expected %h last %b",
                         i, obs[i].data, obs[i].last, tag(s, (i / 4) * 2 + (i % 2)), i % 2 == 1);
            end
            if (i > 0) begin
                vectors++;
                if (obs[i].cyc != obs[i-1].cyc + ((i % 2 == 0) ? 2 : 1)) begin
                    miscompares++;
                    $display("FAIL t2_spacing%0d: got %0d cycles expected %0d", i, obs[i].cyc - obs[i-1].cyc, (i % 2 == 0) ? 2 : 1);
                end
            end
        end
        @(posedge clk);
        #1;
        vectors++; if (pkt_cnt0 !== 2'd3 || pkt_cnt1 !== 2'd3) begin miscompares++; $display("FAIL t2_cnt: got %0d/%0d expected 3/3", pkt_cnt0, pkt_cnt1); end
    endtask

    task automatic test_stall();
        do_reset();
        for (int j = 0; j < 4; j++) push(0, tag(0, 16'h30 + j), 4'hF, j == 3);
        for (int j = 0; j < 2; j++) push(1, tag(1, 16'h40 + j), 4'hF, j == 1);
        wait_beats(2, 20, "t3_first");
        @(posedge clk);
        #2;
        m_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            vectors++;
            if (m00.tvalid !== 1'b1 || m00.tdata !== tag(0, 16'h32) || s00.tready !== 1'b0 || s01.tready !== 1'b0) begin
                miscompares++;
                $display("FAIL t3_hold%0d: got valid %b data %h rdy %b%b expected 1 %h 00",
                         c, m00.tvalid, m00.tdata, s00.tready, s01.tready, tag(0, 16'h32));
            end
        end
        @(posedge clk);
        #2;
        m_ready = 1'b1;
        wait_beats(6, 30, "t3_rest");
        for (int i = 2; i < 6 && i < obs.size(); i++) begin
            vectors++;
            if (obs[i].data !== ((i < 4) ? tag(0, 16'h30 + i) : tag(1, 16'h40 + i - 4))) begin
                miscompares++;
                $display("FAIL t3_order%0d: got %h expected %h", i, obs[i].data, (i < 4) ? tag(0, 16'h30 + i) : tag(1, 16'h40 + i - 4));
            end
        end
        if (obs.size() >= 5) begin
            vectors++;
            if (obs[4].cyc != obs[3].cyc + 2 || obs[3].last !== 1'b1) begin
                miscompares++;
                $display("FAIL t3_handover: got gap %0d last %b expected 2 1", obs[4].cyc - obs[3].cyc, obs[3].last);
            end
        end
    endtask

    task automatic test_overrun();
        do_reset();
        for (int j = 0; j < 6; j++) push(0, tag(0, 16'h50 + j), 4'hF, j == 5);
        wait_beats(6, 30, "t4_beats");
        for (int i = 0; i < 6 && i < obs.size(); i++) begin
            vectors++;
            if (obs[i].data !== tag(0, 16'h50 + i) || obs[i].last !== (i == 3 || i == 5)) begin
                miscompares++;
                $display("FAIL t4_beat%0d: got %h last %b expected %h last %b", i, obs[i].data, obs[i].last, tag(0, 16'h50 + i), i == 3 || i == 5);
            end
        end
        if (obs.size() >= 5) begin
            vectors++;
            if (obs[4].cyc != obs[3].cyc + 2) begin miscompares++; $display("FAIL t4_gap: got %0d expected 2", obs[4].cyc - obs[3].cyc); end
        end
        @(posedge clk);
        #1;
        vectors++; if (err_overrun !== 1'b1) begin miscompares++; $display("FAIL t4_err: got %b expected 1", err_overrun); end
        vectors++; if (pkt_cnt0 !== 2'd2) begin miscompares++; $display("FAIL t4_cnt0: got %0d expected 2", pkt_cnt0); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        push(0, tag(0, 16'h70), 4'hF, 1'b1);
        wait_beats(1, 20, "t5_pre");
        for (int j = 0; j < 5; j++) push(1, tag(1, 16'h60 + j), 4'hF, j == 4);
        wait_beats(2, 20, "t5_first");
        @(posedge clk);
        #3;
        vectors++;
        if (m00.tvalid !== 1'b1 || m00.tdata !== tag(1, 16'h61) || pkt_cnt0 !== 2'd1) begin
            miscompares++;
            $display("FAIL t5_beat2: got valid %b data %h cnt0 %0d expected 1 %h 1", m00.tvalid, m00.tdata, pkt_cnt0, tag(1, 16'h61));
        end
        rst_n = 1'b0;
        #1;
        vectors++; if (m00.tvalid !== 1'b0) begin miscompares++; $display("FAIL t5_tvalid: got %b expected 0", m00.tvalid); end
        vectors++; if (s00.tready !== 1'b0 || s01.tready !== 1'b0) begin miscompares++; $display("FAIL t5_tready: got %b%b expected 00", s00.tready, s01.tready); end
        vectors++; if (pkt_cnt0 !== '0 || pkt_cnt1 !== '0) begin miscompares++; $display("FAIL t5_cnt: got %0d/%0d expected 0/0", pkt_cnt0, pkt_cnt1); end
        q0.delete();
        q1.delete();
        push(0, tag(0, 16'h80), 4'hF, 1'b1);
        push(1, tag(1, 16'h81), 4'hF, 1'b1);
        repeat (2) @(posedge clk);
        #2;
        obs.delete();
        rst_n = 1'b1;
        wait_beats(2, 20, "t5_after");
        if (obs.size() >= 2) begin
            vectors++;
            if (obs[0].data !== tag(0, 16'h80) || obs[1].data !== tag(1, 16'h81)) begin
                miscompares++;
                $display("FAIL t5_regrant: got %h,%h expected %h,%h", obs[0].data, obs[1].data, tag(0, 16'h80), tag(1, 16'h81));
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push(1, tag(1, 16'h90 + i), 4'h1, 1'b1);
            wait_beats(i + 1, 20, "t6_beat");
            @(posedge clk);
            #1;
            vectors++;
            if (pkt_cnt1 !== CW'((i + 1) % 4)) begin
                miscompares++;
                $display("FAIL t6_cnt1_%0d: got %0d expected %0d", i, pkt_cnt1, (i + 1) % 4);
            end
        end
        vectors++; if (err_overrun !== 1'b0) begin miscompares++; $display("FAIL t6_err: got %b expected 0", err_overrun); end
    endtask

    task automatic test_random(input int round);
        beat_t src0[$], src1[$], e0[$], e1[$], expq[$];
        int    seg0[$], seg1[$];
        bit    forced;
        int    np, len, lg, pick, n, k, c0, c1;
        beat_t b;
        do_reset();
        forced = 1'b0;
        for (int s = 0; s < 2; s++) begin
            np = $urandom_range(2, 5);
            for (int p = 0; p < np; p++) begin
                len = $urandom_range(1, 7);
                for (int j = 0; j < len; j++) begin
                    b.data = {s[0], 31'($urandom)};
                    b.strb = SW'($urandom);
                    b.last = (j == len - 1);
                    b.cyc  = 0;
                    if (s == 0) src0.push_back(b); else src1.push_back(b);
                end
            end
        end
        split(src0, e0, seg0, forced);
        split(src1, e1, seg1, forced);
        c0 = seg0.size();
        c1 = seg1.size();
        lg = 1;
        while (seg0.size() > 0 || seg1.size() > 0) begin
            if (seg0.size() > 0 && seg1.size() > 0) pick = (lg == 1) ? 0 : 1;
            else pick = (seg0.size() > 0) ? 0 : 1;
            lg = pick;
            if (pick == 0) begin
                n = seg0.pop_front();
                repeat (n) expq.push_back(e0.pop_front());
            end else begin
                n = seg1.pop_front();
                repeat (n) expq.push_back(e1.pop_front());
            end
        end
        foreach (src0[j]) q0.push_back(src0[j]);
        foreach (src1[j]) q1.push_back(src1[j]);
        k = 0;
        while (obs.size() < expq.size() && k < 3000) begin
            @(posedge clk);
            #2;
            m_ready = ($urandom_range(0, 3) != 0);
            k++;
        end
        m_ready = 1'b1;
        vectors++;
        if (obs.size() != expq.size()) begin
            miscompares++;
            $display("FAIL rnd%0d_len: got %0d beats expected %0d", round, obs.size(), expq.size());
        end
        for (int i = 0; i < expq.size() && i < obs.size(); i++) begin
            vectors++;
            if (obs[i].data !== expq[i].data || obs[i].strb !== expq[i].strb || obs[i].last !== expq[i].last) begin
                miscompares++;
                $display("FAIL rnd%0d_beat%0d: got %h/%h/%b expected %h/%h/%b", round, i,
                         obs[i].data, obs[i].strb, obs[i].last, expq[i].data, expq[i].strb, expq[i].last);
            end
            if (i > 0 && obs[i-1].last === 1'b1) begin
                vectors++;
                if (obs[i].cyc < obs[i-1].cyc + 2) begin
                    miscompares++;
                    $display("FAIL rnd%0d_gap%0d: got %0d cycles expected at least 2", round, i, obs[i].cyc - obs[i-1].cyc);
                end
            end
        end
        @(posedge clk);
        #1;
        vectors++;
        if (pkt_cnt0 !== CW'(c0) || pkt_cnt1 !== CW'(c1)) begin
            miscompares++;
            $display("FAIL rnd%0d_cnt: got %0d/%0d expected %0d/%0d", round, pkt_cnt0, pkt_cnt1, c0 % 4, c1 % 4);
        end
        vectors++;
        if (err_overrun !== forced) begin
            miscompares++;
            $display("FAIL rnd%0d_err: got %b expected %b", round, err_overrun, forced);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_overrun();
        test_reset_mid();
        test_wrap();
        for (int r = 0; r < 4; r++) test_random(r);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
